mont_mul_responder: RTL

- Bit-serial radix-2 Montgomery multiplier. Computes result = A·B·2^(-WIDTH) mod M.
- Acts as the responder side of the start/done multiplier handshake used by the exponentiation ladder controllers. Two instances serve each ladder.
- Latches its operands on start. Pulses done when the result is valid. Holds the result until the next accepted start.

---
 rtl/mont_mul_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/mont_mul_responder.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Responder side of the start/done handshake; one loop iteration per clock.
module mont_mul_responder #(
  parameter int unsigned WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StLoop, StSub, StDone} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH+1:0]   r_c;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_done;
  logic               r_busy;

  logic [WIDTH+1:0]   w_t1;
  logic [WIDTH+1:0]   w_t2;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;

  // C + B*a_i, then add M if odd so the shift by one is exact.
  assign w_t1   = r_c + (r_a[0] ? {2'b00, r_b} : '0);
  assign w_t2   = w_t1 + (w_t1[0] ? {2'b00, r_m} : '0);
  // C < 2M, so only the low WIDTH bits of C - M are needed once C >= M.
  assign w_ge   = (r_c >= {2'b00, r_m});
  assign w_diff = r_c[WIDTH-1:0] - r_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_c      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // Outputs trail the state by one cycle so done lands WIDTH+2 edges after accept.
      r_busy <= (r_state != StIdle);
      r_done <= (r_state == StDone);
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_m     <= in_m;
            r_c     <= '0;
            r_cnt   <= '0;
            r_state <= StLoop;
          end
        end
        StLoop: begin
          r_c   <= w_t2 >> 1;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntW'(WIDTH - 1)) begin
            r_state <= StSub;
          end
        end
        StSub: begin
          r_result <= w_ge ? w_diff : r_c[WIDTH-1:0];
          r_state  <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule
